// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
//   Turns the signed control word from the truncation stage into a two-leg PWM
//   drive for the servo H-bridge. The magnitude is shifted and saturated to the
//   period length. Duty, direction and saturation are loaded only on period
//   boundaries. A direction reversal holds both legs low for DEAD_CYC cycles at
//   the start of the first period in the new direction.
//
// Handshake: en is a valid-only capture strobe with no ready. u is taken into
//   u_hold on every rising edge where en=1. A value captured on the edge that
//   starts a period is not seen until the following boundary.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   en           in   control-word valid strobe
//   u            in   signed control word [cant_bits-1:0]
//   pwm_pos      out  H-bridge positive leg (registered)
//   pwm_neg      out  H-bridge negative leg (registered)
//   period_tick  out  one-cycle pulse in the cnt=0 cycle of every period
//   sat          out  duty of the current period was clipped to PERIOD
module servo_pwm_driver #(
    parameter int cant_bits = 16,
    parameter int PERIOD    = 1000,
    parameter int SHIFT     = 5,
    parameter int DEAD_CYC  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [cant_bits-1:0] u,
    output logic                        pwm_pos,
    output logic                        pwm_neg,
    output logic                        period_tick,
    output logic                        sat
);

    // One extra bit so that PERIOD = 2^cant_bits and the shifted magnitude
    // share a common width for every compare.
    localparam int XW = cant_bits + 1;
    localparam logic [XW-1:0] PERIOD_X = XW'(PERIOD);
    localparam logic [XW-1:0] LAST_X   = XW'(PERIOD - 1);
    localparam logic [XW-1:0] DEAD_X   = XW'(DEAD_CYC);
    localparam logic signed [cant_bits-1:0] U_MIN = {1'b1, {(cant_bits-1){1'b0}}};
    localparam logic [cant_bits-1:0]        U_MAX = {1'b0, {(cant_bits-1){1'b1}}};

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_t;

    // Registered state
    logic signed [cant_bits-1:0] u_hold;
    logic [XW-1:0]               cnt;
    logic [XW-1:0]               duty;
    logic                        dir_neg;   // 0 = POS, 1 = NEG
    logic                        armed;     // low until the first post-reset boundary
    state_t                      state;

    // Next-state values
    logic [XW-1:0]        cnt_n;
    logic [XW-1:0]        duty_n;
    logic                 dir_neg_n;
    logic                 sat_n;
    state_t               state_n;
    logic                 pos_n;
    logic                 neg_n;
    logic                 tick_n;

    // Boundary-load datapath
    logic                 boundary;
    logic [cant_bits-1:0] mag;
    logic [XW-1:0]        mag_s;
    logic [XW-1:0]        duty_calc;
    logic                 sat_calc;
    logic                 dir_calc;
    logic                 dead_pending;
    logic                 leg_on;

    // Magnitude with the most negative code folded onto the most positive one,
    // so the result always fits in cant_bits-1 bits.
    always_comb begin
        mag = $unsigned(u_hold);
        if (u_hold[cant_bits-1]) begin
            if (u_hold == U_MIN) begin
                mag = U_MAX;
            end else begin
                mag = $unsigned(-u_hold);
            end
        end
    end

    always_comb begin
        mag_s     = {1'b0, mag} >> SHIFT;
        sat_calc  = (mag_s > PERIOD_X);
        duty_calc = sat_calc ? PERIOD_X : mag_s;
        // A zero duty carries no direction information, so it never flips
        // the bridge and never costs a dead-time window.
        dir_calc     = (duty_calc == '0) ? dir_neg : u_hold[cant_bits-1];
        dead_pending = (dir_calc != dir_neg);
    end

    // Next-state / output decode. Outputs are computed from the values the
    // registers will hold in the next cycle, so each registered output lines
    // up with the cnt of the same cycle.
    always_comb begin
        boundary  = !armed || (cnt == LAST_X);
        cnt_n     = cnt + XW'(1);
        duty_n    = duty;
        dir_neg_n = dir_neg;
        sat_n     = sat;
        state_n   = state;
        tick_n    = boundary;

        if (boundary) begin
            cnt_n     = '0;
            duty_n    = duty_calc;
            dir_neg_n = dir_calc;
            sat_n     = sat_calc;
            state_n   = (dead_pending && (DEAD_X != '0)) ? DEAD : RUN;
        end else if ((state == DEAD) && (cnt_n == DEAD_X)) begin
            state_n = RUN;
        end

        leg_on = (state_n == RUN) && (cnt_n < duty_n);
        pos_n  = leg_on && !dir_neg_n;
        neg_n  = leg_on && dir_neg_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u_hold      <= '0;
            cnt         <= '0;
            duty        <= '0;
            dir_neg     <= 1'b0;
            sat         <= 1'b0;
            armed       <= 1'b0;
            state       <= RUN;
            pwm_pos     <= 1'b0;
            pwm_neg     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            if (en) begin
                u_hold <= u;
            end
            cnt         <= cnt_n;
            duty        <= duty_n;
            dir_neg     <= dir_neg_n;
            sat         <= sat_n;
            armed       <= 1'b1;
            state       <= state_n;
            pwm_pos     <= pos_n;
            pwm_neg     <= neg_n;
            period_tick <= tick_n;
        end
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver
//   Directed bench for servo_pwm_driver at the default parameters
//   (cant_bits=16, PERIOD=1000, SHIFT=5, DEAD_CYC=8). Expected on-times,
//   first-high positions and saturation flags are hand-computed in the table.
module tb_servo_pwm_driver;

    localparam int PER = 1000;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [15:0] u;
    logic               pwm_pos;
    logic               pwm_neg;
    logic               period_tick;
    logic               sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [15:0] u;
        int                 pos_on;
        int                 neg_on;
        int                 first;
        int                 sat;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    servo_pwm_driver #(
        .cant_bits (16),
        .PERIOD    (PER),
        .SHIFT     (5),
        .DEAD_CYC  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .u           (u),
        .pwm_pos     (pwm_pos),
        .pwm_neg     (pwm_neg),
        .period_tick (period_tick),
        .sat         (sat)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        while (period_tick !== 1'b1 && n < 2 * PER) begin
            step();
            n++;
        end
        check($sformatf("%s.tick_wait", name), int'(period_tick === 1'b1), 1);
    endtask

    // Observes one full period starting at the current (tick) cycle and ends
    // positioned on the first cycle of the next period.
    task automatic measure(input string name, input int e_pos, input int e_neg,
                           input int e_first, input int e_sat);
        int n_pos, n_neg, first, last, both, ticks, tick0, n_sat, e_last;
        n_pos = 0; n_neg = 0; first = -1; last = -1;
        both = 0; ticks = 0; tick0 = 0; n_sat = 0;
        for (int i = 0; i < PER; i++) begin
            if (pwm_pos === 1'b1) n_pos++;
            if (pwm_neg === 1'b1) n_neg++;
            if (pwm_pos === 1'b1 || pwm_neg === 1'b1) begin
                if (first < 0) first = i;
                last = i;
            end
            if (pwm_pos === 1'b1 && pwm_neg === 1'b1) both++;
            if (period_tick === 1'b1) begin
                ticks++;
                if (i == 0) tick0 = 1;
            end
            if (sat === 1'b1) n_sat++;
            step();
        end
        e_last = (e_first < 0) ? -1 : e_first + e_pos + e_neg - 1;
        check($sformatf("%s.pos_on", name), n_pos, e_pos);
        check($sformatf("%s.neg_on", name), n_neg, e_neg);
        check($sformatf("%s.first_high", name), first, e_first);
        check($sformatf("%s.last_high", name), last, e_last);
        check($sformatf("%s.overlap", name), both, 0);
        check($sformatf("%s.tick_count", name), ticks, 1);
        check($sformatf("%s.tick_at_cnt0", name), tick0, 1);
        check($sformatf("%s.sat_cycles", name), n_sat, (e_sat != 0) ? PER : 0);
    endtask

    task automatic check_quiet(input string name);
        check($sformatf("%s.pwm_pos", name), int'(pwm_pos), 0);
        check($sformatf("%s.pwm_neg", name), int'(pwm_neg), 0);
        check($sformatf("%s.tick", name), int'(period_tick), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(2_000_000);
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / stimulus ----------------
    initial begin
        //         u       pos  neg  first sat
        vecs[0]  = '{16'sd16000,   500,   0,  0, 0};
        vecs[1]  = '{-16'sd32768,    0, 992,  8, 1};  // reversal + clip
        vecs[2]  = '{-16'sd32768,    0,1000,  0, 1};  // full period, no gap
        vecs[3]  = '{16'sd6400,    192,   0,  8, 0};  // reversal
        vecs[4]  = '{16'sd6400,    200,   0,  0, 0};
        vecs[5]  = '{-16'sd6400,     0, 192,  8, 0};  // reversal
        vecs[6]  = '{-16'sd6400,     0, 200,  0, 0};
        vecs[7]  = '{16'sd31,        0,   0, -1, 0};  // duty 0, dir kept NEG
        vecs[8]  = '{-16'sd3200,     0, 100,  0, 0};  // no dead time
        vecs[9]  = '{16'sd0,         0,   0, -1, 0};
        vecs[10] = '{16'sd32767,   992,   0,  8, 1};  // reversal + clip
        vecs[11] = '{16'sd31999,   999,   0,  0, 0};
        vecs[12] = '{16'sd32000,  1000,   0,  0, 0};  // exactly PERIOD
        vecs[13] = '{16'sd32032,  1000,   0,  0, 1};  // PERIOD+1 clipped

        rst = 1'b1;
        en  = 1'b0;
        u   = '0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet($sformatf("reset%0d", i));
            check($sformatf("reset%0d.sat", i), int'(sat), 0);
        end
        rst = 1'b0;
        step();
        check("start.tick", int'(period_tick), 1);
        check("start.pwm_pos", int'(pwm_pos), 0);
        check("start.pwm_neg", int'(pwm_neg), 0);
        measure("period0", 0, 0, -1, 0);

        // Table-driven vectors: pulse en at cnt 0, observe the next period
        for (int i = 0; i < NV; i++) begin
            en = 1'b1;
            u  = vecs[i].u;
            step();
            en = 1'b0;
            wait_tick($sformatf("vec%0d", i));
            measure($sformatf("vec%0d", i), vecs[i].pos_on, vecs[i].neg_on,
                    vecs[i].first, vecs[i].sat);
        end

        // Late capture: en on the edge ending cnt=998 applies next period
        repeat (998) step();
        check("late.tick_cnt998", int'(period_tick), 0);
        en = 1'b1;
        u  = 16'sd3200;
        step();
        en = 1'b0;
        check("late.tick_cnt999", int'(period_tick), 0);
        step();
        check("late.tick_boundary", int'(period_tick), 1);
        measure("late", 100, 0, 0, 0);

        // Capture on the boundary edge itself: old value this period, new next
        repeat (999) step();
        en = 1'b1;
        u  = 16'sd9600;
        step();
        en = 1'b0;
        check("ontick.tick", int'(period_tick), 1);
        measure("ontick_old", 100, 0, 0, 0);
        measure("ontick_new", 300, 0, 0, 0);

        // en held high all period: the edge ending cnt=998 decides
        for (int i = 0; i < PER; i++) begin
            en = 1'b1;
            u  = (i == PER - 2) ? 16'sd12800 : 16'sd3200;
            step();
        end
        en = 1'b0;
        measure("en_held", 400, 0, 0, 0);

        // Reset in the middle of a high pulse (duty 100 now, u_hold=3200)
        repeat (50) step();
        check("midrst.pre_pos", int'(pwm_pos), 1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet($sformatf("midrst%0d", i));
        end
        rst = 1'b0;
        step();
        check("midrst.tick", int'(period_tick), 1);
        check("midrst.sat", int'(sat), 0);
        measure("post_reset", 0, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
